// File: rtl/btn_pkg.sv
// Shared types and 100 MHz default timing constants for the front-panel button conditioner.
package btn_pkg;

    typedef enum logic [1:0] {
        S_LOW  = 2'd0,
        S_RISE = 2'd1,
        S_HIGH = 2'd2,
        S_FALL = 2'd3
    } btn_state_t;

    typedef enum logic {
        FIRST = 1'b0,
        NEXT  = 1'b1
    } rpt_phase_t;

    localparam int unsigned N_BTN_DEF       = 5;
    localparam int unsigned DB_CYCLES_DEF   = 1_000_000;   // 10 ms
    localparam int unsigned HOLD_CYCLES_DEF = 50_000_000;  // 500 ms
    localparam int unsigned RPT_CYCLES_DEF  = 10_000_000;  // 100 ms

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage : btn_pkg

// File: rtl/btn_debounce_ch.sv
// One button channel: 2-flop synchroniser, stability-counter debounce FSM and auto-repeat timer.
module btn_debounce_ch
    import btn_pkg::*;
#(
    parameter int unsigned DB_CYCLES   = DB_CYCLES_DEF,
    parameter int unsigned REPEAT_EN   = 1,
    parameter int unsigned HOLD_CYCLES = HOLD_CYCLES_DEF,
    parameter int unsigned RPT_CYCLES  = RPT_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    output logic btn_level,
    output logic btn_press,
    output logic btn_release,
    output logic btn_rpt
);

    localparam int unsigned CNT_W  = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam int unsigned HOLD_MAX = max_u(HOLD_CYCLES, RPT_CYCLES);
    localparam int unsigned HOLD_W = (HOLD_MAX > 1) ? $clog2(HOLD_MAX) : 1;

    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(DB_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [HOLD_W-1:0] RPT_LAST  = HOLD_W'(RPT_CYCLES - 1);

    logic              sync_meta;
    logic              sync;
    btn_state_t        state_q;
    btn_state_t        state_d;
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  cnt_d;
    logic [HOLD_W-1:0] hold_q;
    logic [HOLD_W-1:0] hold_d;
    rpt_phase_t        phase_q;
    rpt_phase_t        phase_d;
    logic              level_d;
    logic              press_d;
    logic              release_d;
    logic              rpt_d;
    logic              rpt_hit_c;

    // Two-flop synchroniser for the asynchronous pin
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_meta <= 1'b0;
            sync      <= 1'b0;
        end else begin
            sync_meta <= btn;
            sync      <= sync_meta;
        end
    end

    // State, counters and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_LOW;
            cnt_q       <= '0;
            hold_q      <= '0;
            phase_q     <= FIRST;
            btn_level   <= 1'b0;
            btn_press   <= 1'b0;
            btn_release <= 1'b0;
            btn_rpt     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            hold_q      <= hold_d;
            phase_q     <= phase_d;
            btn_level   <= level_d;
            btn_press   <= press_d;
            btn_release <= release_d;
            btn_rpt     <= rpt_d;
        end
    end

    // Repeat terminal count depends on whether the first repeat has fired yet
    assign rpt_hit_c = (phase_q == FIRST) ? (hold_q == HOLD_LAST) : (hold_q == RPT_LAST);

    // Next-state, counter and pulse logic
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        hold_d    = hold_q;
        phase_d   = phase_q;
        level_d   = btn_level;
        press_d   = 1'b0;
        release_d = 1'b0;
        rpt_d     = 1'b0;

        case (state_q)
            S_LOW: begin
                if (sync) begin
                    state_d = S_RISE;
                    cnt_d   = '0;
                end
            end

            S_RISE: begin
                if (!sync) begin
                    state_d = S_LOW;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = S_HIGH;
                    level_d = 1'b1;
                    press_d = 1'b1;
                    hold_d  = '0;
                    phase_d = FIRST;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            S_HIGH: begin
                if (!sync) begin
                    state_d = S_FALL;
                    cnt_d   = '0;
                end else if (REPEAT_EN != 0) begin
                    if (rpt_hit_c) begin
                        rpt_d   = 1'b1;
                        hold_d  = '0;
                        phase_d = NEXT;
                    end else begin
                        hold_d = hold_q + 1'b1;
                    end
                end
            end

            S_FALL: begin
                // A bounce back high resumes the hold timer where it froze
                if (sync) begin
                    state_d = S_HIGH;
                end else if (cnt_q == CNT_LAST) begin
                    state_d   = S_LOW;
                    level_d   = 1'b0;
                    release_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            default: begin
                state_d = S_LOW;
            end
        endcase
    end

endmodule : btn_debounce_ch

// File: rtl/btn_conditioner.sv
// Front-panel button conditioner: N_BTN independent debounce/edge/repeat channels.
module btn_conditioner
    import btn_pkg::*;
#(
    parameter int unsigned N_BTN       = N_BTN_DEF,
    parameter int unsigned DB_CYCLES   = DB_CYCLES_DEF,
    parameter int unsigned REPEAT_EN   = 1,
    parameter int unsigned HOLD_CYCLES = HOLD_CYCLES_DEF,
    parameter int unsigned RPT_CYCLES  = RPT_CYCLES_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_BTN-1:0] btn,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_press,
    output logic [N_BTN-1:0] btn_release,
    output logic [N_BTN-1:0] btn_rpt
);

    for (genvar i = 0; i < int'(N_BTN); i++) begin : g_ch
        btn_debounce_ch #(
            .DB_CYCLES   (DB_CYCLES),
            .REPEAT_EN   (REPEAT_EN),
            .HOLD_CYCLES (HOLD_CYCLES),
            .RPT_CYCLES  (RPT_CYCLES)
        ) u_ch (
            .clk         (clk),
            .rst_n       (rst_n),
            .btn         (btn[i]),
            .btn_level   (btn_level[i]),
            .btn_press   (btn_press[i]),
            .btn_release (btn_release[i]),
            .btn_rpt     (btn_rpt[i])
        );
    end

endmodule : btn_conditioner
